chip8_mem_ctrl: RTL

//  Responder side of the CHIP-8 CPU memory bus. Owns the 4 KiB byte RAM. After reset it

---
 rtl/chip8_pkg.sv | 26 ++
 rtl/chip8_mem_if.sv | 30 +++
 rtl/chip8_font_rom.sv | 50 +++++
 rtl/chip8_mem_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
// Shared state encoding and address constants for the CHIP-8 memory controller.
// The CLEAR state exists only when CHIP8_MEM_CLEAR_EN is defined.
package chip8_pkg;

  localparam logic [11:0] DEF_FONT_BASE   = 12'h050;
  localparam logic [11:0] DEF_PROG_BASE   = 12'h200;
  localparam logic [11:0] DEF_PROTECT_TOP = 12'h1FF;
  localparam int          FONT_LEN        = 80;
  localparam int          MEM_DEPTH       = 4096;

`ifdef CHIP8_MEM_CLEAR_EN
  typedef enum logic [1:0] {
    ST_CLEAR     = 2'd0,
    ST_INIT_FONT = 2'd1,
    ST_LOAD      = 2'd2,
    ST_RUN       = 2'd3
  } mem_state_e;
`else
  typedef enum logic [1:0] {
    ST_INIT_FONT = 2'd1,
    ST_LOAD      = 2'd2,
    ST_RUN       = 2'd3
  } mem_state_e;
`endif

endpackage

// File: rtl/chip8_mem_if.sv
// CPU bus and ROM-loader stream seen by the CHIP-8 memory controller.
// master = CPU/loader side, slave = memory controller side.
interface chip8_mem_if;

  logic        cpu_mem_read;
  logic        cpu_mem_write;
  logic [11:0] cpu_mem_addr;
  logic [7:0]  cpu_mem_wdata;
  logic [7:0]  cpu_mem_rdata;
  logic        cpu_hold;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_overflow;
  logic        wr_violation;

  modport master (
    output cpu_mem_read, cpu_mem_write, cpu_mem_addr, cpu_mem_wdata,
    output ld_valid, ld_data, ld_last,
    input  cpu_mem_rdata, cpu_hold, ld_ready, ld_overflow, wr_violation
  );

  modport slave (
    input  cpu_mem_read, cpu_mem_write, cpu_mem_addr, cpu_mem_wdata,
    input  ld_valid, ld_data, ld_last,
    output cpu_mem_rdata, cpu_hold, ld_ready, ld_overflow, wr_violation
  );

endinterface

// File: rtl/chip8_font_rom.sv
// Combinational 80x8 CHIP-8 hex font: 16 glyphs of 5 rows, glyph n at index 5n.
module chip8_font_rom
  import chip8_pkg::*;
(
  input  logic [6:0] idx,
  output logic [7:0] data
);

  logic [3:0]  glyph_sel_s;
  logic [2:0]  row_s;
  logic [39:0] glyph_s;

  // Split the flat index into glyph/row, then pick the row byte (top row in the MSBs).
  always_comb begin
    glyph_sel_s = 4'(idx / 7'd5);
    row_s       = 3'(idx % 7'd5);
    case (glyph_sel_s)
      4'h0:    glyph_s = 40'hF0_90_90_90_F0;
      4'h1:    glyph_s = 40'h20_60_20_20_70;
      4'h2:    glyph_s = 40'hF0_10_F0_80_F0;
      4'h3:    glyph_s = 40'hF0_10_F0_10_F0;
      4'h4:    glyph_s = 40'h90_90_F0_10_10;
      4'h5:    glyph_s = 40'hF0_80_F0_10_F0;
      4'h6:    glyph_s = 40'hF0_80_F0_90_F0;
      4'h7:    glyph_s = 40'hF0_10_20_40_40;
      4'h8:    glyph_s = 40'hF0_90_F0_90_F0;
      4'h9:    glyph_s = 40'hF0_90_F0_10_F0;
      4'hA:    glyph_s = 40'hF0_90_F0_90_90;
      4'hB:    glyph_s = 40'hE0_90_E0_90_E0;
      4'hC:    glyph_s = 40'hF0_80_80_80_F0;
      4'hD:    glyph_s = 40'hE0_90_90_90_E0;
      4'hE:    glyph_s = 40'hF0_80_F0_80_F0;
      4'hF:    glyph_s = 40'hF0_80_F0_80_80;
      default: glyph_s = 40'h00_00_00_00_00;
    endcase
    if (idx >= 7'(FONT_LEN)) begin
      data = 8'h00;
    end else begin
      case (row_s)
        3'd0:    data = glyph_s[39:32];
        3'd1:    data = glyph_s[31:24];
        3'd2:    data = glyph_s[23:16];
        3'd3:    data = glyph_s[15:8];
        3'd4:    data = glyph_s[7:0];
        default: data = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/chip8_mem_ctrl.sv
// CHIP-8 memory controller: owns the 4 KiB RAM, preloads the font, takes the program
// stream, then serves the CPU. Define CHIP8_MEM_CLEAR_EN to zero the RAM first.
module chip8_mem_ctrl
  import chip8_pkg::*;
#(
  parameter logic [11:0] FONT_BASE   = DEF_FONT_BASE,
  parameter logic [11:0] PROG_BASE   = DEF_PROG_BASE,
  parameter logic [11:0] PROTECT_TOP = DEF_PROTECT_TOP
) (
  input logic        clk,
  input logic        reset_n,
  chip8_mem_if.slave bus
);

`ifdef CHIP8_MEM_CLEAR_EN
  localparam mem_state_e RESET_STATE = ST_CLEAR;
  logic [11:0] clr_addr_r, clr_addr_s;
`else
  localparam mem_state_e RESET_STATE = ST_INIT_FONT;
`endif

  mem_state_e  state_r, state_s;
  logic [6:0]  font_idx_r, font_idx_s;
  logic [11:0] load_ptr_r, load_ptr_s;
  logic        ld_overflow_r, ld_overflow_s;
  logic        wr_violation_r, wr_violation_s;
  logic        mem_we_s;
  logic [11:0] mem_addr_s;
  logic [7:0]  mem_wdata_s;
  logic [7:0]  font_byte_s;
  logic [7:0]  mem_r [MEM_DEPTH];
  logic        unused_read_s;

  chip8_font_rom u_font_rom (
    .idx  (font_idx_r),
    .data (font_byte_s)
  );

  // Control state and sticky flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= RESET_STATE;
      font_idx_r     <= 7'd0;
      load_ptr_r     <= PROG_BASE;
      ld_overflow_r  <= 1'b0;
      wr_violation_r <= 1'b0;
`ifdef CHIP8_MEM_CLEAR_EN
      clr_addr_r     <= 12'h000;
`endif
    end else begin
      state_r        <= state_s;
      font_idx_r     <= font_idx_s;
      load_ptr_r     <= load_ptr_s;
      ld_overflow_r  <= ld_overflow_s;
      wr_violation_r <= wr_violation_s;
`ifdef CHIP8_MEM_CLEAR_EN
      clr_addr_r     <= clr_addr_s;
`endif
    end
  end

  // Next-state logic and the single RAM write port, muxed by state.
  always_comb begin
    state_s        = state_r;
    font_idx_s     = font_idx_r;
    load_ptr_s     = load_ptr_r;
    ld_overflow_s  = ld_overflow_r;
    wr_violation_s = wr_violation_r;
    mem_we_s       = 1'b0;
    mem_addr_s     = 12'h000;
    mem_wdata_s    = 8'h00;
`ifdef CHIP8_MEM_CLEAR_EN
    clr_addr_s     = clr_addr_r;
`endif
    case (state_r)
`ifdef CHIP8_MEM_CLEAR_EN
      ST_CLEAR: begin
        mem_we_s   = 1'b1;
        mem_addr_s = clr_addr_r;
        clr_addr_s = clr_addr_r + 12'd1;
        if (clr_addr_r == 12'hFFF) begin
          state_s = ST_INIT_FONT;
        end else begin
          state_s = ST_CLEAR;
        end
      end
`endif
      ST_INIT_FONT: begin
        mem_we_s    = 1'b1;
        mem_addr_s  = FONT_BASE + {5'd0, font_idx_r};
        mem_wdata_s = font_byte_s;
        if (font_idx_r == 7'(FONT_LEN - 1)) begin
          state_s = ST_LOAD;
        end else begin
          font_idx_s = font_idx_r + 7'd1;
        end
      end
      ST_LOAD: begin
        if (bus.ld_valid) begin
          // Once the top address has been written, further bytes are swallowed.
          if (!ld_overflow_r) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = load_ptr_r;
            mem_wdata_s = bus.ld_data;
            if (load_ptr_r == 12'hFFF) begin
              ld_overflow_s = 1'b1;
            end else begin
              load_ptr_s = load_ptr_r + 12'd1;
            end
          end else begin
            mem_we_s = 1'b0;
          end
          if (bus.ld_last) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (bus.cpu_mem_write) begin
          if (bus.cpu_mem_addr > PROTECT_TOP) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = bus.cpu_mem_addr;
            mem_wdata_s = bus.cpu_mem_wdata;
          end else begin
            wr_violation_s = 1'b1;
          end
        end else begin
          mem_we_s = 1'b0;
        end
      end
      default: begin
        state_s = RESET_STATE;
      end
    endcase
  end

  // RAM array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_addr_s] <= mem_wdata_s;
    end
  end

  // Read data is always driven in RUN, so the read strobe carries no state.
  assign unused_read_s     = bus.cpu_mem_read;
  assign bus.cpu_mem_rdata = (state_r == ST_RUN) ? mem_r[bus.cpu_mem_addr] : 8'h00;
  assign bus.cpu_hold      = (state_r != ST_RUN);
  assign bus.ld_ready      = (state_r == ST_LOAD);
  assign bus.ld_overflow   = ld_overflow_r;
  assign bus.wr_violation  = wr_violation_r;

endmodule
